// File: rtl/wired_bus_arb_pkg.sv
// rtl/wired_bus_arb_pkg.sv - shared types for the two-way refill/uncached port arbiter
package wired_bus_arb_pkg;

  // Field widths of the stored request; the top-level ADDR_W/DATA_W must not exceed these
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 128;
  localparam int ARB_STRB_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } bus_arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic                  write;
    logic [1:0]            len;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_STRB_W-1:0] wstrb;
  } arb_req_t;

endpackage

// File: rtl/wired_rr_picker.sv
// rtl/wired_rr_picker.sv - 2-way one-hot picker; WIRED_BUS_ARB_RR_EN selects round-robin over fixed priority
module wired_rr_picker
  import wired_bus_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic [1:0] i_mask,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  logic [1:0] w_req;
  assign w_req = i_valid & ~i_mask;

`ifdef WIRED_BUS_ARB_RR_EN
  // Tie goes to the requester that did not win last time
  always_comb begin
    o_grant = w_req;
    if (w_req == 2'b11) begin
      o_grant = i_last_grant ? 2'b01 : 2'b10;
    end
  end
`else
  // History is tracked by the top but only round-robin consumes it
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;

  // Tie always goes to the data cache (requester 1)
  always_comb begin
    o_grant = w_req;
    if (w_req == 2'b11) begin
      o_grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/wired_bus_arb.sv
// rtl/wired_bus_arb.sv - I$/D$ arbiter for the shared TileLink refill port (WIRED_BUS_ARB_RR_EN: round-robin ties)
module wired_bus_arb
  import wired_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [1:0][ADDR_W-1:0]       req_addr_i,
  input  logic [1:0]                   req_write_i,
  input  logic [1:0][1:0]              req_len_i,
  input  logic [1:0][DATA_W-1:0]       req_wdata_i,
  input  logic [1:0][DATA_W/8-1:0]     req_wstrb_i,
  output logic [1:0]                   resp_valid_o,
  output logic                         resp_last_o,
  output logic [DATA_W-1:0]            resp_data_o,
  output logic                         m_req_valid_o,
  input  logic                         m_req_ready_i,
  output logic [ADDR_W-1:0]            m_req_addr_o,
  output logic                         m_req_write_o,
  output logic [1:0]                   m_req_len_o,
  output logic [DATA_W-1:0]            m_req_wdata_o,
  output logic [DATA_W/8-1:0]          m_req_wstrb_o,
  output logic                         m_req_src_o,
  input  logic                         m_resp_valid_i,
  output logic                         m_resp_ready_o,
  input  logic                         m_resp_last_i,
  input  logic [DATA_W-1:0]            m_resp_data_i
);

  bus_arb_state_t r_state;
  arb_req_t       r_req;
  logic           r_owner;
  logic           r_m_req_valid;
  logic           r_flush_pending;
  logic           r_last_grant;

  logic [1:0]     w_grant;
  logic           w_sel;
  logic           w_last_beat;
  logic           w_in_resp;

  // Flush only hides the fetch side, and only in the cycle it is asserted
  wired_rr_picker u_picker (
    .i_valid      (req_valid_i),
    .i_mask       ({1'b0, flush_i}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_sel       = w_grant[1];
  assign w_last_beat = m_resp_valid_i && m_resp_last_i;
  assign w_in_resp   = (r_state == RESP);

  // Single FSM: grant and capture, hold the master request, then route or discard beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_req           <= '0;
      r_owner         <= 1'b0;
      r_m_req_valid   <= 1'b0;
      r_flush_pending <= 1'b0;
      r_last_grant    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant != 2'b00) begin
            r_req.addr    <= ARB_ADDR_W'(req_addr_i[w_sel]);
            r_req.write   <= req_write_i[w_sel];
            r_req.len     <= req_len_i[w_sel];
            r_req.wdata   <= ARB_DATA_W'(req_wdata_i[w_sel]);
            r_req.wstrb   <= ARB_STRB_W'(req_wstrb_i[w_sel]);
            r_owner       <= w_sel;
            r_last_grant  <= w_sel;
            r_m_req_valid <= 1'b1;
            r_state       <= ISSUE;
          end
        end
        ISSUE: begin
          // The master request cannot be withdrawn, so a fetch flush is remembered instead
          if (flush_i && !r_owner) begin
            r_flush_pending <= 1'b1;
          end
          if (m_req_ready_i) begin
            r_m_req_valid <= 1'b0;
            if (!r_owner && (r_flush_pending || flush_i)) begin
              r_flush_pending <= 1'b0;
              r_state         <= DRAIN;
            end else begin
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          if (w_last_beat) begin
            r_state <= IDLE;
          end else if (flush_i && !r_owner) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last_beat) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o    = (r_state == IDLE) ? w_grant : 2'b00;

  assign m_req_valid_o  = r_m_req_valid;
  assign m_req_addr_o   = ADDR_W'(r_req.addr);
  assign m_req_write_o  = r_req.write;
  assign m_req_len_o    = r_req.len;
  assign m_req_wdata_o  = DATA_W'(r_req.wdata);
  assign m_req_wstrb_o  = (DATA_W/8)'(r_req.wstrb);
  assign m_req_src_o    = r_owner;

  // Beats are always sunk once the request is out; stray beats before that are refused
  assign m_resp_ready_o = (r_state == RESP) || (r_state == DRAIN);

  assign resp_valid_o   = (w_in_resp && m_resp_valid_i) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_last_o    = w_in_resp && m_resp_last_i;
  assign resp_data_o    = w_in_resp ? m_resp_data_i : '0;

endmodule
